hog_block_normalizer: RTL

Downstream consumer of the cell-histogram stage. After the histogram stage signals completion, the block walks every cell of the feature map in raster order. For each cell it reads NBINS accumulated bins from the 4-bank cell BRAM over the port-A read interface, L1-normalises each bin against the cell's bin sum, and streams one fixed-point feature per bin to the PCA/hamming stage. After the last feature it pulses write_feature_done, which releases the histogram stage for the next frame.

---
 rtl/hog_pkg.sv | 49 ++++
 rtl/hog_seq_divider.sv | 95 +++++++++
 rtl/hog_block_normalizer.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hog_pkg.sv
// Shared constants, FSM encoding and BRAM bank/address mapping for the
// HOG block normaliser.
package hog_pkg;

  localparam int TOTAL_BIT_WIDTH = 35;
  localparam int NBINS           = 18;
  localparam int CELLS_X         = 34;
  localparam int CELLS_Y         = 34;
  localparam int FRAC            = 15;
  localparam int OUT_W           = FRAC + 1;
  localparam int READ_LAT        = 2;
  localparam int ADDR_W          = 13;
  // Cell bin sum: NBINS words of TOTAL_BIT_WIDTH cannot overflow 5 extra bits.
  localparam int SUM_W           = TOTAL_BIT_WIDTH + 5;
  // Divider dividend is the bin value scaled up by FRAC bits.
  localparam int DVD_W           = TOTAL_BIT_WIDTH + FRAC;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SUM      = 3'd1,
    ST_SUM_WAIT = 3'd2,
    ST_RD       = 3'd3,
    ST_DIV      = 3'd4,
    ST_OUT      = 3'd5,
    ST_DONE     = 3'd6
  } state_e;

  // Tag that travels alongside an outstanding BRAM read.
  typedef struct packed {
    logic       vld;
    logic [1:0] bank;
  } rd_tag_t;

  // Even/odd row and column parity picks one of the four banks.
  function automatic logic [1:0] bank_of(input logic [5:0] row, input logic [5:0] col);
    return {row[0], col[0]};
  endfunction

  // In-bank word address of (row, col, bin) for a map that is cells_x wide.
  function automatic logic [ADDR_W-1:0] bank_addr(input logic [5:0] row,
                                                  input logic [5:0] col,
                                                  input logic [4:0] bin,
                                                  input int         cells_x);
    int a;
    a = (int'(row >> 1) * (cells_x >> 1) + int'(col >> 1)) * NBINS + int'(bin);
    return a[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/hog_seq_divider.sv
// Restoring divider, one quotient bit per cycle. The quotient is known to
// fit in OUT_W bits (bin <= sum), so the partial remainder is seeded with
// the dividend bits above the quotient window and only OUT_W steps run.
module hog_seq_divider
  import hog_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [DVD_W-1:0] dividend_i,
  input  logic [SUM_W-1:0] divisor_i,
  output logic             done_o,
  output logic [OUT_W-1:0] quotient_o
);

  logic [SUM_W-1:0] rem_q, rem_d;
  logic [SUM_W-1:0] dsr_q, dsr_d;
  logic [OUT_W-1:0] low_q, low_d;
  logic [OUT_W-1:0] quo_q, quo_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             run_q, run_d;
  logic             done_q, done_d;

  logic [SUM_W:0]   trial_s;
  logic [SUM_W:0]   diff_s;
  logic             fits_s;

  // Trial subtraction of the shifted partial remainder.
  always_comb begin
    trial_s = {rem_q, low_q[OUT_W-1]};
    diff_s  = trial_s - {1'b0, dsr_q};
    fits_s  = (trial_s >= {1'b0, dsr_q});
  end

  // Load on start, then shift/subtract until all quotient bits are produced.
  always_comb begin
    rem_d  = rem_q;
    dsr_d  = dsr_q;
    low_d  = low_q;
    quo_d  = quo_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = 1'b0;
    if (start_i) begin
      rem_d = SUM_W'(dividend_i[DVD_W-1:OUT_W]);
      low_d = dividend_i[OUT_W-1:0];
      dsr_d = divisor_i;
      quo_d = {OUT_W{1'b0}};
      cnt_d = 5'(OUT_W);
      run_d = 1'b1;
    end else if (run_q) begin
      if (fits_s) begin
        rem_d = diff_s[SUM_W-1:0];
      end else begin
        rem_d = trial_s[SUM_W-1:0];
      end
      quo_d = {quo_q[OUT_W-2:0], fits_s};
      low_d = {low_q[OUT_W-2:0], 1'b0};
      cnt_d = cnt_q - 5'd1;
      if (cnt_q == 5'd1) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end else begin
        run_d  = 1'b1;
      end
    end else begin
      run_d = 1'b0;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rem_q  <= {SUM_W{1'b0}};
      dsr_q  <= {SUM_W{1'b0}};
      low_q  <= {OUT_W{1'b0}};
      quo_q  <= {OUT_W{1'b0}};
      cnt_q  <= 5'd0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      dsr_q  <= dsr_d;
      low_q  <= low_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign done_o     = done_q;
  assign quotient_o = quo_q;

endmodule

// File: rtl/hog_block_normalizer.sv
// HOG block normaliser: walks every cell in raster order, sums its bins,
// then L1-normalises each bin and streams it out with valid/ready.
module hog_block_normalizer
  import hog_pkg::*;
#(
  parameter int N_CELLS_X = CELLS_X,
  parameter int N_CELLS_Y = CELLS_Y
) (
  input  logic                       aclk,
  input  logic                       arest,
  input  logic                       histogram_done,
  output logic [ADDR_W-1:0]          normal_addra_0,
  output logic [ADDR_W-1:0]          normal_addra_1,
  output logic [ADDR_W-1:0]          normal_addra_2,
  output logic [ADDR_W-1:0]          normal_addra_3,
  input  logic [TOTAL_BIT_WIDTH-1:0] douta_0,
  input  logic [TOTAL_BIT_WIDTH-1:0] douta_1,
  input  logic [TOTAL_BIT_WIDTH-1:0] douta_2,
  input  logic [TOTAL_BIT_WIDTH-1:0] douta_3,
  output logic [OUT_W-1:0]           feat_data,
  output logic [4:0]                 feat_bin,
  output logic [5:0]                 feat_cell_row,
  output logic [5:0]                 feat_cell_col,
  output logic                       feat_last,
  output logic                       feat_valid,
  input  logic                       feat_ready,
  output logic                       write_feature_done,
  output logic                       busy
);

  state_e                     state_q, state_d;
  logic [5:0]                 row_q, row_d;
  logic [5:0]                 col_q, col_d;
  logic [4:0]                 bin_q, bin_d;
  logic [4:0]                 rcv_q, rcv_d;
  logic                       rd_issued_q, rd_issued_d;
  logic [SUM_W-1:0]           sum_q, sum_d;
  logic [TOTAL_BIT_WIDTH-1:0] binv_q, binv_d;
  logic                       div_start_q, div_start_d;

  logic [ADDR_W-1:0]          addr_q [4];
  logic [ADDR_W-1:0]          addr_d [4];
  rd_tag_t                    tag_q, tag_d;
  rd_tag_t                    pipe_q [READ_LAT];

  logic [OUT_W-1:0]           feat_data_q, feat_data_d;
  logic [4:0]                 feat_bin_q, feat_bin_d;
  logic [5:0]                 feat_row_q, feat_row_d;
  logic [5:0]                 feat_col_q, feat_col_d;
  logic                       feat_last_q, feat_last_d;
  logic                       feat_valid_q, feat_valid_d;
  logic                       done_q, done_d;
  logic                       busy_q, busy_d;

  logic                       issue_s;
  logic [1:0]                 bank_s;
  logic [ADDR_W-1:0]          issue_addr_s;
  logic                       rd_vld_s;
  logic [TOTAL_BIT_WIDTH-1:0] rd_data_s;
  logic                       last_cell_s;
  logic                       last_bin_s;
  logic                       div_done_s;
  logic [OUT_W-1:0]           div_quo_s;

  hog_seq_divider u_div (
    .clk_i      (aclk),
    .rst_i      (arest),
    .start_i    (div_start_q),
    .dividend_i ({binv_q, {FRAC{1'b0}}}),
    .divisor_i  (sum_q),
    .done_o     (div_done_s),
    .quotient_o (div_quo_s)
  );

  // Current cell position, bank and returning-read demux.
  always_comb begin
    bank_s       = bank_of(row_q, col_q);
    issue_addr_s = bank_addr(row_q, col_q, bin_q, N_CELLS_X);
    last_cell_s  = (row_q == 6'(N_CELLS_Y - 1)) && (col_q == 6'(N_CELLS_X - 1));
    last_bin_s   = (bin_q == 5'(NBINS - 1));
    rd_vld_s     = pipe_q[READ_LAT-1].vld;
    case (pipe_q[READ_LAT-1].bank)
      2'd0:    rd_data_s = douta_0;
      2'd1:    rd_data_s = douta_1;
      2'd2:    rd_data_s = douta_2;
      2'd3:    rd_data_s = douta_3;
      default: rd_data_s = douta_0;
    endcase
  end

  // Frame walk FSM: next state, counters and output-register next values.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    bin_d        = bin_q;
    rcv_d        = rcv_q;
    rd_issued_d  = rd_issued_q;
    sum_d        = sum_q;
    binv_d       = binv_q;
    div_start_d  = 1'b0;
    issue_s      = 1'b0;
    feat_data_d  = feat_data_q;
    feat_bin_d   = feat_bin_q;
    feat_row_d   = feat_row_q;
    feat_col_d   = feat_col_q;
    feat_last_d  = feat_last_q;

    // Bin words returning during the summing phase feed the cell sum.
    if (rd_vld_s && ((state_q == ST_SUM) || (state_q == ST_SUM_WAIT))) begin
      sum_d = sum_q + SUM_W'(rd_data_s);
      rcv_d = rcv_q + 5'd1;
    end else begin
      sum_d = sum_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (histogram_done) begin
          state_d = ST_SUM;
          row_d   = 6'd0;
          col_d   = 6'd0;
          bin_d   = 5'd0;
          rcv_d   = 5'd0;
          sum_d   = {SUM_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SUM: begin
        issue_s = 1'b1;
        if (last_bin_s) begin
          bin_d   = 5'd0;
          state_d = ST_SUM_WAIT;
        end else begin
          bin_d   = bin_q + 5'd1;
        end
      end
      ST_SUM_WAIT: begin
        if (rd_vld_s && (rcv_q == 5'(NBINS - 1))) begin
          state_d     = ST_RD;
          bin_d       = 5'd0;
          rd_issued_d = 1'b0;
        end else begin
          state_d = ST_SUM_WAIT;
        end
      end
      ST_RD: begin
        if (!rd_issued_q) begin
          issue_s     = 1'b1;
          rd_issued_d = 1'b1;
        end else if (rd_vld_s) begin
          binv_d      = rd_data_s;
          div_start_d = (sum_q != {SUM_W{1'b0}});
          state_d     = ST_DIV;
        end else begin
          state_d = ST_RD;
        end
      end
      ST_DIV: begin
        // An all-zero cell bypasses the divider and yields zero features.
        if (sum_q == {SUM_W{1'b0}}) begin
          feat_data_d = {OUT_W{1'b0}};
          state_d     = ST_OUT;
        end else if (div_done_s) begin
          feat_data_d = div_quo_s;
          state_d     = ST_OUT;
        end else begin
          state_d = ST_DIV;
        end
        feat_bin_d  = bin_q;
        feat_row_d  = row_q;
        feat_col_d  = col_q;
        feat_last_d = last_cell_s && last_bin_s;
      end
      ST_OUT: begin
        if (feat_ready) begin
          rd_issued_d = 1'b0;
          if (!last_bin_s) begin
            bin_d   = bin_q + 5'd1;
            state_d = ST_RD;
          end else if (last_cell_s) begin
            bin_d   = 5'd0;
            state_d = ST_DONE;
          end else begin
            bin_d   = 5'd0;
            rcv_d   = 5'd0;
            sum_d   = {SUM_W{1'b0}};
            state_d = ST_SUM;
            if (col_q == 6'(N_CELLS_X - 1)) begin
              col_d = 6'd0;
              row_d = row_q + 6'd1;
            end else begin
              col_d = col_q + 6'd1;
            end
          end
        end else begin
          state_d = ST_OUT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    feat_valid_d = (state_d == ST_OUT);
    done_d       = (state_d == ST_DONE);
    busy_d       = (state_d != ST_IDLE) && (state_d != ST_DONE);
  end

  // Only the selected bank sees a non-zero address, and only while reading.
  always_comb begin
    for (int b = 0; b < 4; b++) begin
      if (issue_s && (bank_s == 2'(b))) begin
        addr_d[b] = issue_addr_s;
      end else begin
        addr_d[b] = {ADDR_W{1'b0}};
      end
    end
    tag_d.vld  = issue_s;
    tag_d.bank = bank_s;
  end

  // State, datapath and output registers.
  always_ff @(posedge aclk) begin
    if (arest) begin
      state_q      <= ST_IDLE;
      row_q        <= 6'd0;
      col_q        <= 6'd0;
      bin_q        <= 5'd0;
      rcv_q        <= 5'd0;
      rd_issued_q  <= 1'b0;
      sum_q        <= {SUM_W{1'b0}};
      binv_q       <= {TOTAL_BIT_WIDTH{1'b0}};
      div_start_q  <= 1'b0;
      tag_q        <= '0;
      feat_data_q  <= {OUT_W{1'b0}};
      feat_bin_q   <= 5'd0;
      feat_row_q   <= 6'd0;
      feat_col_q   <= 6'd0;
      feat_last_q  <= 1'b0;
      feat_valid_q <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      for (int b = 0; b < 4; b++) begin
        addr_q[b] <= {ADDR_W{1'b0}};
      end
      for (int i = 0; i < READ_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      bin_q        <= bin_d;
      rcv_q        <= rcv_d;
      rd_issued_q  <= rd_issued_d;
      sum_q        <= sum_d;
      binv_q       <= binv_d;
      div_start_q  <= div_start_d;
      tag_q        <= tag_d;
      feat_data_q  <= feat_data_d;
      feat_bin_q   <= feat_bin_d;
      feat_row_q   <= feat_row_d;
      feat_col_q   <= feat_col_d;
      feat_last_q  <= feat_last_d;
      feat_valid_q <= feat_valid_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      for (int b = 0; b < 4; b++) begin
        addr_q[b] <= addr_d[b];
      end
      // Read tags age in step with the BRAM latency.
      pipe_q[0] <= tag_q;
      for (int i = 1; i < READ_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign normal_addra_0     = addr_q[0];
  assign normal_addra_1     = addr_q[1];
  assign normal_addra_2     = addr_q[2];
  assign normal_addra_3     = addr_q[3];
  assign feat_data          = feat_data_q;
  assign feat_bin           = feat_bin_q;
  assign feat_cell_row      = feat_row_q;
  assign feat_cell_col      = feat_col_q;
  assign feat_last          = feat_last_q;
  assign feat_valid         = feat_valid_q;
  assign write_feature_done = done_q;
  assign busy               = busy_q;

endmodule
